// File: rtl/jtpang_dwn_pkg.sv
// rtl/jtpang_dwn_pkg.sv - shared types and helpers for the jtpang ROM download path
//
// Purpose: parameter defaults, the 33-bit queued write entry and the OBJ
// address swizzle shared by the programming FIFO and its storage.
// Ports: none (package).

package jtpang_dwn_pkg;

  localparam int unsigned HEADER_DEF     = 16;
  localparam logic [24:0] BA1_START_DEF  = 25'h0;
  localparam logic [24:0] BA2_START_DEF  = 25'h0;
  localparam logic [24:0] BA3_START_DEF  = 25'h0;
  localparam logic [24:0] PROM_START_DEF = 25'h1FFFFFF;

  // One queued SDRAM byte write. Lane is kept as a single bit and the mask
  // and duplicated data word are rebuilt on the way out.
  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [7:0]  dbyte;
    logic        lane;
  } prog_entry_t;

  localparam int unsigned ENTRY_W = $bits(prog_entry_t);

  // OBJ layout: byte-address bits [5:1] become {a[4:1],a[5]}, i.e. the low
  // five word-address bits rotate left by one.
  function automatic logic [21:0] obj_swizzle(input logic [21:0] w);
    return {w[21:5], w[3:0], w[4]};
  endfunction

endpackage

// File: rtl/jtpang_prog_fifo_mem.sv
// rtl/jtpang_prog_fifo_mem.sv - small register FIFO holding queued SDRAM writes
//
// Purpose: DEPTH x W storage with read/write pointers carrying an extra wrap
// bit so full and empty are told apart without a counter.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pointers only)
//   push, din        write one entry (caller guarantees !full || pop)
//   pop              discard the head entry (caller guarantees !empty)
//   dout             current head entry, valid while !empty
//   full, empty      occupancy flags

module jtpang_prog_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // On full+push+pop the write lands in the slot being vacated; the old
    // head has already been presented combinationally this cycle.
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is visible while the pointers say empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/jtpang_prog_fifo.sv
// rtl/jtpang_prog_fifo.sv - ROM download front end for the SDRAM programming port
//
// Purpose: strips and captures the stream header (Kabuki key), maps each
// downloaded byte to bank / word address / lane, swizzles OBJ addresses,
// strobes PROM bytes out directly and queues SDRAM writes behind a
// prog_we/prog_ack handshake.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   downloading                      download window active
//   ioctl_addr/ioctl_dout/ioctl_wr   incoming byte stream
//   header, kabuki_we, kabuki_en     header decode and Kabuki key control
//   prom_we                          one-cycle strobe for PROM bytes
//   prog_addr/data/mask/ba/we        SDRAM write request (held until ack)
//   prog_ack                         SDRAM accepted the presented entry
//   dwnld_busy                       download active or writes still queued
//   ovf                              sticky drop flag, cleared on a new download

module jtpang_prog_fifo
  import jtpang_dwn_pkg::*;
#(
  parameter int unsigned HEADER     = HEADER_DEF,
  parameter logic [24:0] BA1_START  = BA1_START_DEF,
  parameter logic [24:0] BA2_START  = BA2_START_DEF,
  parameter logic [24:0] BA3_START  = BA3_START_DEF,
  parameter logic [24:0] PROM_START = PROM_START_DEF,
  parameter bit          SWAB       = 1'b1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic        header,
  output logic        kabuki_we,
  output logic        kabuki_en,
  output logic        prom_we,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic        dwnld_busy,
  output logic        ovf
);

  localparam logic [24:0] HDR = 25'(HEADER);

  logic        kabuki_en_q, kabuki_en_d;
  logic        prom_we_q, prom_we_d;
  logic        ovf_q, ovf_d;
  logic        dwn_q, dwn_d;

  logic        wr_ok, in_prom, sdram_wr, push, pop, drop;
  logic        full, empty;
  logic [24:0] off, base, rel;
  logic [1:0]  ba;
  logic [21:0] waddr;
  prog_entry_t push_entry, head;
  logic        unused_rel;

  // Strobes outside the download window are ignored entirely.
  assign wr_ok     = ioctl_wr && downloading;
  assign header    = ioctl_addr < HDR;
  assign kabuki_we = wr_ok && header && (ioctl_addr[3:0] < 4'd11);
  assign off       = ioctl_addr - HDR;
  assign in_prom   = off >= PROM_START;

  always_comb begin
    ba   = 2'd0;
    base = 25'd0;
    if (off >= BA3_START) begin
      ba   = 2'd3;
      base = BA3_START;
    end else if (off >= BA2_START) begin
      ba   = 2'd2;
      base = BA2_START;
    end else if (off >= BA1_START) begin
      ba   = 2'd1;
      base = BA1_START;
    end
    rel   = off - base;
    waddr = rel[22:1];
    if (ba == 2'd3) begin
      waddr = obj_swizzle(waddr);
    end
    push_entry       = '0;
    push_entry.ba    = ba;
    push_entry.addr  = waddr;
    push_entry.dbyte = ioctl_dout;
    push_entry.lane  = off[0] ^ SWAB;
  end

  assign unused_rel = ^{rel[24:23], rel[0]};

  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign pop      = prog_we && prog_ack;
  assign sdram_wr = wr_ok && !header && !in_prom;
  assign push     = sdram_wr && (!full || pop);
  assign drop     = sdram_wr && full && !pop;

  jtpang_prog_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    kabuki_en_d = kabuki_en_q;
    if (kabuki_we && (ioctl_addr[3:0] == 4'd0)) begin
      kabuki_en_d = (ioctl_dout != 8'd0);
    end
    prom_we_d = wr_ok && !header && in_prom;
    dwn_d     = downloading;
    ovf_d     = ovf_q;
    if (downloading && !dwn_q) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kabuki_en_q <= 1'b0;
      prom_we_q   <= 1'b0;
      ovf_q       <= 1'b0;
      dwn_q       <= 1'b0;
    end else begin
      kabuki_en_q <= kabuki_en_d;
      prom_we_q   <= prom_we_d;
      ovf_q       <= ovf_d;
      dwn_q       <= dwn_d;
    end
  end

  // The request is the FIFO head itself, so it changes only on push-to-empty
  // or pop, and drops with the pointer reset. Fields read zero when idle.
  assign prog_we    = !empty;
  assign prog_ba    = prog_we ? head.ba : 2'd0;
  assign prog_addr  = prog_we ? head.addr : 22'd0;
  assign prog_data  = prog_we ? {head.dbyte, head.dbyte} : 16'd0;
  assign prog_mask  = !prog_we ? 2'b00 : (head.lane ? 2'b01 : 2'b10);
  assign dwnld_busy = downloading || !empty;
  assign kabuki_en  = kabuki_en_q;
  assign prom_we    = prom_we_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_jtpang_prog_fifo.sv
// tb/tb_jtpang_prog_fifo.sv - self-checking bench for jtpang_prog_fifo

module tb_jtpang_prog_fifo;

  localparam logic [24:0] BA1 = 25'h100;
  localparam logic [24:0] BA2 = 25'h800;
  localparam logic [24:0] BA3 = 25'h1000;
  localparam logic [24:0] PRM = 25'h2000;
  localparam int          SWB = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_ack = 1'b0;
  logic        header, kabuki_we, kabuki_en, prom_we, prog_we, dwnld_busy, ovf;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;

  int n_cmp = 0;
  int n_err = 0;
  logic [41:0] exp_q[$];

  jtpang_prog_fifo #(
    .HEADER(16), .BA1_START(BA1), .BA2_START(BA2), .BA3_START(BA3),
    .PROM_START(PRM), .SWAB(1'b1), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .header(header), .kabuki_we(kabuki_we), .kabuki_en(kabuki_en),
    .prom_we(prom_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we),
    .prog_ack(prog_ack), .dwnld_busy(dwnld_busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected {ba, word addr, data, mask} from the mapping rules, in plain arithmetic.
  function automatic logic [41:0] model(input logic [24:0] a, input logic [7:0] d);
    int unsigned off, base, w, lo;
    logic [1:0] ba, m;
    off = a - 16;
    if (off >= BA3)      begin ba = 2'd3; base = BA3; end
    else if (off >= BA2) begin ba = 2'd2; base = BA2; end
    else if (off >= BA1) begin ba = 2'd1; base = BA1; end
    else                 begin ba = 2'd0; base = 0;   end
    w = ((off - base) / 2) % (1 << 22);
    if (ba == 2'd3) begin
      lo = w % 32;
      w  = w - lo + ((lo * 2) % 32) + (lo / 16);
    end
    m = (((off % 2) ^ SWB) == 1) ? 2'b01 : 2'b10;
    return {ba, w[21:0], d, d, m};
  endfunction

  function automatic logic [24:0] rand_addr(input int region);
    case (region)
      0:       return 25'(16 + $urandom_range(0, 'hFF));
      1:       return 25'(16 + $urandom_range('h100, 'h7FF));
      2:       return 25'(16 + $urandom_range('h800, 'hFFF));
      3:       return 25'(16 + $urandom_range('h1000, 'h1FFF));
      default: return 25'(16 + $urandom_range('h2000, 'h20FF));
    endcase
  endfunction

  // Called and returns at posedge+1; holds the strobe for one cycle.
  task automatic put(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic put_model(input logic [24:0] a, input logic [7:0] d);
    put(a, d);
    if (a - 16 < PRM) begin
      if (exp_q.size() < 4) exp_q.push_back(model(a, d));
    end
  endtask

  task automatic drain(input string nm);
    logic [41:0] e, got;
    int n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      @(negedge clk);
      while (!prog_we && n < 16) begin @(negedge clk); n++; end
      got = {prog_ba, prog_addr, prog_data, prog_mask};
      n_cmp++;
      if (prog_we !== 1'b1) begin
        n_err++; $display("FAIL %s_timeout: prog_we got %b want 1", nm, prog_we);
      end else if (got !== e) begin
        n_err++; $display("FAIL %s_entry: got %h want %h", nm, got, e);
      end
      prog_ack = 1'b1;
      @(posedge clk); #1;
      prog_ack = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (prog_we !== 1'b0 || dwnld_busy !== downloading) begin
      n_err++; $display("FAIL %s_idle: we/busy got %b%b want 0%b", nm, prog_we, dwnld_busy, downloading);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({prog_we, prom_we, kabuki_en, ovf, dwnld_busy, prog_addr, prog_data, prog_mask, prog_ba} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %b%b%b%b%b %h %h %b %b want all zero", prog_we, prom_we,
                        kabuki_en, ovf, dwnld_busy, prog_addr, prog_data, prog_mask, prog_ba);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    downloading = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_header;
    logic bad = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ioctl_addr = 25'(a);
      ioctl_dout = (a == 0) ? 8'h01 : 8'($urandom);
      ioctl_wr   = 1'b1;
      @(negedge clk);
      if (header !== 1'b1 || kabuki_we !== (a < 11) || prog_we !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL header_byte%0d: hdr/kwe/we got %b%b%b want 1%b0", a, header, kabuki_we, prog_we, a < 11);
      end
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      if (prom_we !== 1'b0) begin
        bad = 1'b1; $display("FAIL header_prom: prom_we got 1 want 0");
      end
    end
    n_cmp++;
    if (bad) n_err++;
    @(negedge clk);
    n_cmp++;
    if (kabuki_en !== 1'b1 || prog_we !== 1'b0) begin
      n_err++; $display("FAIL header_kabuki_en: en/we got %b%b want 10", kabuki_en, prog_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bank0_pair;
    put_model(25'd16, 8'hAA);
    @(negedge clk);
    n_cmp++;
    if (prog_we !== 1'b1) begin
      n_err++; $display("FAIL latency: prog_we got %b want 1", prog_we);
    end
    @(posedge clk); #1;
    put_model(25'd17, 8'h55);
    drain("bank0_pair");
  endtask

  task automatic test_ignored;
    downloading = 1'b0;
    @(posedge clk); #1;
    put(25'd0, 8'h00);
    put(25'd21, 8'h33);
    put(25'(16) + PRM, 8'h44);
    @(negedge clk);
    n_cmp++;
    if (prog_we !== 1'b0 || kabuki_en !== 1'b1 || prom_we !== 1'b0) begin
      n_err++; $display("FAIL ignored: we/ken/prom got %b%b%b want 010", prog_we, kabuki_en, prom_we);
    end
    @(posedge clk); #1;
    downloading = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_obj_swizzle;
    put_model(25'd16 + 25'h1020, 8'h5A);
    @(negedge clk);
    n_cmp++;
    if (prog_ba !== 2'd3 || prog_addr !== 22'h01) begin
      n_err++; $display("FAIL obj_swizzle: ba/addr got %0d/%h want 3/000001", prog_ba, prog_addr);
    end
    @(posedge clk); #1;
    drain("obj_swizzle");
  endtask

  task automatic test_random;
    logic [24:0] a;
    int r;
    for (int round = 0; round < 8; round++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        r = $urandom_range(0, 4);
        a = rand_addr(r);
        put_model(a, 8'($urandom));
        @(negedge clk);
        n_cmp++;
        if (prom_we !== (r == 4)) begin
          n_err++; $display("FAIL random_prom: prom_we got %b want %b", prom_we, r == 4);
        end
        @(posedge clk); #1;
      end
      drain("random");
    end
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL random_ovf: ovf got %b want 0", ovf);
    end
  endtask

  task automatic test_backpressure;
    logic bad = 1'b0;
    for (int k = 0; k < 6; k++) put_model(rand_addr($urandom_range(0, 3)), 8'($urandom));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (prog_we !== 1'b1 || {prog_ba, prog_addr, prog_data, prog_mask} !== exp_q[0]) begin
        bad = 1'b1; $display("FAIL bp_hold: got %h want %h", {prog_ba, prog_addr, prog_data, prog_mask}, exp_q[0]);
      end
    end
    n_cmp++;
    if (bad) n_err++;
    n_cmp++;
    if (ovf !== 1'b1 || exp_q.size() != 4) begin
      n_err++; $display("FAIL bp_ovf: ovf got %b want 1", ovf);
    end
    @(posedge clk); #1;
    drain("backpressure");
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: ovf got %b want 1", ovf);
    end
    downloading = 1'b0;
    @(posedge clk); #1;
    downloading = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: ovf got %b want 0", ovf);
    end
  endtask

  task automatic test_full_push_pop;
    logic [24:0] a;
    logic [7:0]  d;
    logic [41:0] e;
    for (int k = 0; k < 4; k++) put_model(rand_addr($urandom_range(0, 3)), 8'($urandom));
    a = rand_addr($urandom_range(0, 3));
    d = 8'($urandom);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    prog_ack   = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    exp_q.push_back(model(a, d));
    n_cmp++;
    if ({prog_ba, prog_addr, prog_data, prog_mask} !== e) begin
      n_err++; $display("FAIL fpp_head: got %h want %h", {prog_ba, prog_addr, prog_data, prog_mask}, e);
    end
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    prog_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL fpp_ovf: ovf got %b want 0", ovf);
    end
    @(posedge clk); #1;
    drain("full_push_pop");
  endtask

  task automatic test_dwn_fall;
    put_model(rand_addr(1), 8'($urandom));
    put_model(rand_addr(2), 8'($urandom));
    downloading = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dwnld_busy !== 1'b1) begin
      n_err++; $display("FAIL dwn_fall_busy: got %b want 1", dwnld_busy);
    end
    @(posedge clk); #1;
    drain("dwn_fall");
    downloading = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) put_model(rand_addr($urandom_range(0, 3)), 8'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (prog_we !== 1'b0 || dwnld_busy !== 1'b1 || prog_mask !== 2'b00 || kabuki_en !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: we/busy/mask/ken got %b%b%b%b want 01000", prog_we, dwnld_busy, prog_mask, kabuki_en);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_header();
    test_bank0_pair();
    test_ignored();
    test_obj_swizzle();
    test_random();
    test_backpressure();
    test_full_push_pop();
    test_dwn_fall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
